// File: rtl/bsg_broadcast_fork.sv
// bsg_broadcast_fork: one producer item fanned out to width_p valid/ready lanes,
// retired once every masked lane has accepted. Option: BSG_BROADCAST_FORK_FAST_READY_EN.
module bsg_broadcast_fork #(
  parameter int width_p      = 4,
  parameter int data_width_p = 8,
  parameter int cnt_width_p  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic [width_p-1:0]      mask_i,
  output logic                    ready_o,
  output logic [width_p-1:0]      v_o,
  output logic [data_width_p-1:0] data_o,
  input  logic [width_p-1:0]      ready_i,
  output logic [cnt_width_p-1:0]  done_cnt_o
);

  typedef enum logic {EMPTY, BUSY} state_t;

  state_t                  r_state;
  logic [data_width_p-1:0] r_data;
  logic [width_p-1:0]      r_pending;
  logic [cnt_width_p-1:0]  r_done_cnt;
  logic                    r_ready_en;

  logic [width_p-1:0]      w_lane_ack;
  logic                    w_retire;
  logic                    w_accept;
  logic                    w_zero_accept;
  logic [cnt_width_p-1:0]  w_cnt_inc;

  assign v_o        = (r_state == BUSY) ? r_pending : '0;
  assign data_o     = r_data;
  assign done_cnt_o = r_done_cnt;

  assign w_lane_ack    = v_o & ready_i;
  assign w_retire      = (r_state == BUSY) && ((r_pending & ~w_lane_ack) == '0);
  assign w_accept      = v_i & ready_o;
  assign w_zero_accept = w_accept && (mask_i == '0);
  assign w_cnt_inc     = cnt_width_p'(w_retire) + cnt_width_p'(w_zero_accept);

  // r_ready_en keeps ready_o low during reset and for the first cycle after release.
`ifdef BSG_BROADCAST_FORK_FAST_READY_EN
  assign ready_o = r_ready_en & ((r_state == EMPTY) | w_retire);
`else
  assign ready_o = r_ready_en & (r_state == EMPTY);
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= EMPTY;
      r_data     <= '0;
      r_pending  <= '0;
      r_done_cnt <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_done_cnt <= r_done_cnt + w_cnt_inc;
      if (w_accept) begin
        if (mask_i != '0) begin
          r_data    <= data_i;
          r_pending <= mask_i;
          r_state   <= BUSY;
        end else begin
          r_pending <= '0;
          r_state   <= EMPTY;
        end
      end else if (r_state == BUSY) begin
        r_pending <= r_pending & ~w_lane_ack;
        if (w_retire) r_state <= EMPTY;
      end
    end
  end

endmodule
